seg_scan_monitor: RTL and testbench

//  Passive receiver for the multiplexed 7-segment bus (a..g, dp, an[3:0]) driven by the display driver.

---
 rtl/seg_scan_monitor.sv | 227 ++++++++++++++++++++++
 tb/tb_seg_scan_monitor.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_monitor.sv
// Passive monitor for a multiplexed 7-segment bus: rebuilds the four hex digits, decimal points
// and blink state from the scanned lines, and flags segment patterns that are not hex glyphs.
module seg_scan_monitor #(
    parameter int SETTLE_CYCLES = 4,
    parameter int BLINK_WINDOW  = 25_000_000,
    parameter int WIN_W         = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic       e,
    input  logic       f,
    input  logic       g,
    input  logic       dp,
    input  logic [3:0] an,
    input  logic       err_clr,
    output logic [3:0] digit3,
    output logic [3:0] digit2,
    output logic [3:0] digit1,
    output logic [3:0] digit0,
    output logic [3:0] dp_out,
    output logic [3:0] lit,
    output logic [3:0] blink,
    output logic       frame_done,
    output logic       err
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(BLINK_WINDOW - 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} scanStateT;

    // Returns {hit, value} for an active-low {a..g} pattern.
    function automatic logic [4:0] decodeSeg(input logic [6:0] seg);
        case (seg)
            7'b0000001: decodeSeg = {1'b1, 4'h0};
            7'b1001111: decodeSeg = {1'b1, 4'h1};
            7'b0010010: decodeSeg = {1'b1, 4'h2};
            7'b0000110: decodeSeg = {1'b1, 4'h3};
            7'b1001100: decodeSeg = {1'b1, 4'h4};
            7'b0100100: decodeSeg = {1'b1, 4'h5};
            7'b0100000: decodeSeg = {1'b1, 4'h6};
            7'b0001111: decodeSeg = {1'b1, 4'h7};
            7'b0000000: decodeSeg = {1'b1, 4'h8};
            7'b0000100: decodeSeg = {1'b1, 4'h9};
            7'b0001000: decodeSeg = {1'b1, 4'hA};
            7'b1100000: decodeSeg = {1'b1, 4'hB};
            7'b0110001: decodeSeg = {1'b1, 4'hC};
            7'b1000010: decodeSeg = {1'b1, 4'hD};
            7'b0110000: decodeSeg = {1'b1, 4'hE};
            7'b0111000: decodeSeg = {1'b1, 4'hF};
            default:    decodeSeg = 5'b0;
        endcase
    endfunction

    logic [11:0] busRaw;
    logic [11:0] busMeta_p0;
    logic [11:0] busSync_p1;
    logic [11:0] busPrev_p2;

    assign busRaw = {a, b, c, d, e, f, g, dp, an};

    // Stage p0/p1: two-flop synchronizer; p2 keeps the previous synchronized sample
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busMeta_p0 <= '1;
            busSync_p1 <= '1;
            busPrev_p2 <= '1;
        end else begin
            busMeta_p0 <= busRaw;
            busSync_p1 <= busMeta_p0;
            busPrev_p2 <= busSync_p1;
        end
    end

    logic [6:0] segS;
    logic       dpS;
    logic [3:0] anS;
    logic       changed;
    logic       selLegal;
    logic [1:0] selIdx;

    assign segS    = busSync_p1[11:5];
    assign dpS     = busSync_p1[4];
    assign anS     = busSync_p1[3:0];
    assign changed = busSync_p1 != busPrev_p2;

    always_comb begin
        selLegal = 1'b1;
        selIdx   = 2'd0;
        case (anS)
            4'b1110: selIdx = 2'd0;
            4'b1101: selIdx = 2'd1;
            4'b1011: selIdx = 2'd2;
            4'b0111: selIdx = 2'd3;
            default: selLegal = 1'b0;
        endcase
    end

    scanStateT        stateQ, stateD;
    logic [CNT_W-1:0] cntQ, cntD;
    logic             capture;
    logic             startRun;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ <= IDLE;
            cntQ   <= '0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
        end
    end

    // cntQ holds the stable cycles seen before the current one, so the
    // current cycle completes the dwell when cntQ reaches SETTLE_CYCLES-1.
    always_comb begin
        stateD   = stateQ;
        cntD     = cntQ;
        capture  = 1'b0;
        startRun = 1'b0;
        case (stateQ)
            IDLE: begin
                if (selLegal) startRun = 1'b1;
            end
            SETTLE: begin
                if (changed) begin
                    if (selLegal) startRun = 1'b1;
                    else stateD = IDLE;
                end else if (cntQ == CNT_LAST) begin
                    capture = 1'b1;
                    stateD  = HOLD;
                end else begin
                    cntD = cntQ + 1'b1;
                end
            end
            HOLD: begin
                if (changed) begin
                    if (selLegal) startRun = 1'b1;
                    else stateD = IDLE;
                end
            end
            default: stateD = IDLE;
        endcase
        if (startRun) begin
            cntD = CNT_W'(1);
            if (SETTLE_CYCLES == 1) begin
                capture = 1'b1;
                stateD  = HOLD;
            end else begin
                stateD = SETTLE;
            end
        end
    end

    logic [4:0]       decoded;
    logic [3:0]       capBlank, capLit, capMask, maskNext;
    logic             capBad, frameHit, wrap;
    logic [15:0]      digitsQ;
    logic [3:0]       maskQ, seenBlankQ, seenLitQ;
    logic [WIN_W-1:0] wcntQ;

    always_comb begin
        decoded  = decodeSeg(segS);
        capBlank = 4'b0;
        capLit   = 4'b0;
        capBad   = 1'b0;
        capMask  = 4'b0;
        if (capture) begin
            capMask = 4'b0001 << selIdx;
            if (segS == SEG_BLANK) capBlank = capMask;
            else if (decoded[4]) capLit = capMask;
            else capBad = 1'b1;
        end
    end

    assign maskNext = maskQ | capMask;
    assign frameHit = maskNext == 4'hF;
    assign wrap     = wcntQ == WIN_LAST;

    // Capture stage: digit/lit/dp state, frame mask, blink window and error flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digitsQ    <= '0;
            lit        <= '0;
            dp_out     <= '0;
            blink      <= '0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            maskQ      <= '0;
            seenBlankQ <= '0;
            seenLitQ   <= '0;
            wcntQ      <= '0;
        end else begin
            if ((|capBlank) || (|capLit)) dp_out[selIdx] <= ~dpS;
            if (|capLit) begin
                digitsQ[{selIdx, 2'b00} +: 4] <= decoded[3:0];
                lit[selIdx] <= 1'b1;
            end
            if (|capBlank) lit[selIdx] <= 1'b0;
            frame_done <= frameHit;
            maskQ      <= frameHit ? 4'b0 : maskNext;
            wcntQ      <= wrap ? '0 : wcntQ + 1'b1;
            if (wrap) begin
                blink      <= seenBlankQ & seenLitQ;
                seenBlankQ <= capBlank;
                seenLitQ   <= capLit;
            end else begin
                seenBlankQ <= seenBlankQ | capBlank;
                seenLitQ   <= seenLitQ | capLit;
            end
            if (capBad) err <= 1'b1;
            else if (err_clr) err <= 1'b0;
        end
    end

    assign digit0 = digitsQ[3:0];
    assign digit1 = digitsQ[7:4];
    assign digit2 = digitsQ[11:8];
    assign digit3 = digitsQ[15:12];

endmodule

// File: tb/tb_seg_scan_monitor.sv
// Bench for seg_scan_monitor: directed vector table, multi-cycle corner sequences and random
// scanning, all checked cycle by cycle against a run-length based reference model.
module tb_seg_scan_monitor;

    localparam int S  = 4;
    localparam int W  = 2000;
    localparam int WW = 11;
    localparam logic [6:0] BLANK   = 7'b1111111;
    localparam logic [6:0] BAD     = 7'b1010101;
    localparam logic [3:0] IDLE_AN = 4'b1111;

    logic       clk    = 1'b0;
    logic       rstN   = 1'b1;
    logic [6:0] rawSeg = 7'b1111111;
    logic       rawDp  = 1'b1;
    logic [3:0] rawAn  = 4'b1111;
    logic       errClr = 1'b0;

    logic [3:0] digit3, digit2, digit1, digit0, dpOut, lit, blink;
    logic       frameDone, err;
    logic [29:0] outVec;

    assign outVec = {digit3, digit2, digit1, digit0, dpOut, lit, blink, frameDone, err};

    always #5 clk = ~clk;

    seg_scan_monitor #(
        .SETTLE_CYCLES(S),
        .BLINK_WINDOW (W),
        .WIN_W        (WW)
    ) dut (
        .clk       (clk),
        .reset     (rstN),
        .a         (rawSeg[6]),
        .b         (rawSeg[5]),
        .c         (rawSeg[4]),
        .d         (rawSeg[3]),
        .e         (rawSeg[2]),
        .f         (rawSeg[1]),
        .g         (rawSeg[0]),
        .dp        (rawDp),
        .an        (rawAn),
        .err_clr   (errClr),
        .digit3    (digit3),
        .digit2    (digit2),
        .digit1    (digit1),
        .digit0    (digit0),
        .dp_out    (dpOut),
        .lit       (lit),
        .blink     (blink),
        .frame_done(frameDone),
        .err       (err)
    );

    logic [6:0] segTab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    int nTests   = 0;
    int nFail    = 0;
    int frameCnt = 0;

    // Reference model: raw samples per edge; a capture fires when a legal value
    // has been sampled for exactly S consecutive edges, two edges earlier.
    logic [11:0] hist [$];
    logic [3:0]  mDig [4];
    logic [3:0]  mDp, mLit, mBlink, mSb, mSl, mMask;
    logic        mFrame, mErr;
    int          edgeCnt;

    function automatic logic [29:0] modelVec();
        return {mDig[3], mDig[2], mDig[1], mDig[0], mDp, mLit, mBlink, mFrame, mErr};
    endfunction

    function automatic void modelReset();
        hist.delete();
        for (int k = 0; k < S + 3; k++) hist.push_back(12'hFFF);
        for (int i = 0; i < 4; i++) mDig[i] = 4'h0;
        mDp = 0; mLit = 0; mBlink = 0; mSb = 0; mSl = 0; mMask = 0;
        mFrame = 0; mErr = 0; edgeCnt = 0;
    endfunction

    function automatic void modelEdge();
        logic [11:0] cur;
        bit          cap;
        bit          setE;
        int          idx;
        int          val;
        logic [3:0]  nb, nl;
        hist.push_back({rawSeg, rawDp, rawAn});
        void'(hist.pop_front());
        cur = hist[S];
        cap = ($countones(~cur[3:0]) == 1) && (hist[0] != cur);
        for (int k = 1; k < S; k++) if (hist[k] != cur) cap = 0;
        nb = 0; nl = 0; setE = 0; idx = 0;
        if (cap) begin
            for (int i = 0; i < 4; i++) if (!cur[i]) idx = i;
            val = -1;
            for (int k = 0; k < 16; k++) if (segTab[k] == cur[11:5]) val = k;
            if (cur[11:5] == BLANK) begin
                mLit[idx] = 0; nb[idx] = 1; mDp[idx] = ~cur[4];
            end else if (val >= 0) begin
                mDig[idx] = 4'(val); mLit[idx] = 1; nl[idx] = 1; mDp[idx] = ~cur[4];
            end else begin
                setE = 1;
            end
            mMask[idx] = 1;
        end
        mFrame = (mMask == 4'hF);
        if (mFrame) mMask = 0;
        edgeCnt++;
        if (edgeCnt % W == 0) begin
            mBlink = mSb & mSl; mSb = nb; mSl = nl;
        end else begin
            mSb = mSb | nb; mSl = mSl | nl;
        end
        if (setE) mErr = 1;
        else if (errClr) mErr = 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rstN) modelEdge();
        @(negedge clk);
        check("cycle", {2'b00, outVec}, {2'b00, modelVec()});
        if (frameDone) frameCnt++;
    endtask

    task automatic setBus(input logic [3:0] anV, input logic [6:0] segV, input logic dpV);
        rawAn = anV; rawSeg = segV; rawDp = dpV;
    endtask

    task automatic scan(input logic [3:0] anV, input logic [6:0] segV, input logic dpV, input int dwell);
        setBus(anV, segV, dpV);
        repeat (dwell) step();
    endtask

    task automatic doReset();
        rstN = 1'b0;
        setBus(IDLE_AN, BLANK, 1'b1);
        errClr = 1'b0;
        modelReset();
        #1;
        check("reset_outputs", {2'b00, outVec}, 32'd0);
        repeat (3) step();
        rstN = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
        logic [15:0] expDig;
        logic [3:0]  expLit;
        logic [3:0]  expDp;
        logic        expErr;
        int          expFrames;
    } vecT;

    vecT vecs [8];

    initial begin
        vecs[0] = '{4'b0111, segTab[1], 1'b1, 16'h1000, 4'b1000, 4'b0000, 1'b0, 0};
        vecs[1] = '{4'b1011, segTab[2], 1'b0, 16'h1200, 4'b1100, 4'b0100, 1'b0, 0};
        vecs[2] = '{4'b1101, segTab[3], 1'b1, 16'h1230, 4'b1110, 4'b0100, 1'b0, 0};
        vecs[3] = '{4'b1110, segTab[4], 1'b1, 16'h1234, 4'b1111, 4'b0100, 1'b0, 1};
        vecs[4] = '{4'b1101, BLANK,     1'b1, 16'h1234, 4'b1101, 4'b0100, 1'b0, 0};
        vecs[5] = '{4'b1011, BAD,       1'b1, 16'h1234, 4'b1101, 4'b0100, 1'b1, 0};
        vecs[6] = '{4'b1100, segTab[5], 1'b1, 16'h1234, 4'b1101, 4'b0100, 1'b1, 0};
        vecs[7] = '{4'b1110, segTab[5], 1'b0, 16'h1235, 4'b1101, 4'b0101, 1'b1, 0};

        #2;
        doReset();

        // First capture lands exactly S+2 edges after the bus change
        setBus(4'b1110, segTab[2], 1'b1);
        repeat (S + 1) step();
        check("latency_early_lit0", 32'(lit[0]), 32'd0);
        step();
        check("latency_lit0", 32'(lit[0]), 32'd1);
        check("latency_digit0", 32'(digit0), 32'd2);

        // Multi-low select and a too-short legal dwell must leave no trace
        doReset();
        frameCnt = 0;
        scan(4'b1100, segTab[5], 1'b1, 20);
        scan(4'b0111, segTab[7], 1'b1, S - 1);
        scan(IDLE_AN, BLANK, 1'b1, 10);
        check("glitch_lit", 32'(lit), 32'd0);
        check("glitch_digit3", 32'(digit3), 32'd0);
        check("glitch_frames", 32'(frameCnt), 32'd0);
        check("glitch_err", 32'(err), 32'd0);

        // Illegal pattern, clear, and set winning over a simultaneous clear
        scan(4'b1011, BAD, 1'b1, 10);
        check("bad_err", 32'(err), 32'd1);
        check("bad_digit2", 32'(digit2), 32'd0);
        errClr = 1'b1;
        step();
        errClr = 1'b0;
        check("errclr_err", 32'(err), 32'd0);
        scan(IDLE_AN, BLANK, 1'b1, 10);
        setBus(4'b1011, BAD, 1'b1);
        repeat (S + 1) step();
        check("setclr_pre_err", 32'(err), 32'd0);
        errClr = 1'b1;
        step();
        errClr = 1'b0;
        check("setclr_err", 32'(err), 32'd1);

        // Vector table
        doReset();
        for (int r = 0; r < 8; r++) begin
            frameCnt = 0;
            scan(vecs[r].an, vecs[r].seg, vecs[r].dp, 10);
            check("vec_digits", 32'({digit3, digit2, digit1, digit0}), 32'(vecs[r].expDig));
            check("vec_lit", 32'(lit), 32'(vecs[r].expLit));
            check("vec_dp", 32'(dpOut), 32'(vecs[r].expDp));
            check("vec_err", 32'(err), 32'(vecs[r].expErr));
            check("vec_frames", 32'(frameCnt), 32'(vecs[r].expFrames));
        end

        // Reset in the middle of a scan, then a full scan is needed again
        doReset();
        scan(4'b0111, segTab[1], 1'b1, 10);
        scan(4'b1011, segTab[2], 1'b1, 10);
        check("midrst_pre_digits", 32'({digit3, digit2}), 32'h12);
        setBus(4'b1101, segTab[3], 1'b1);
        repeat (3) step();
        doReset();
        frameCnt = 0;
        scan(4'b1101, segTab[3], 1'b1, 10);
        scan(4'b1110, segTab[4], 1'b1, 10);
        check("midrst_partial_frames", 32'(frameCnt), 32'd0);
        scan(4'b0111, segTab[1], 1'b1, 10);
        scan(4'b1011, segTab[2], 1'b1, 10);
        scan(4'b1101, segTab[3], 1'b1, 10);
        scan(4'b1110, segTab[4], 1'b1, 10);
        check("midrst_full_frames", 32'(frameCnt), 32'd1);

        // Digit1 toggles blank/5 every 8 scans; others stay lit
        doReset();
        frameCnt = 0;
        for (int sc = 0; sc < 60; sc++) begin
            for (int dg = 3; dg >= 0; dg--) begin
                logic [3:0] anSel;
                logic [6:0] segSel;
                anSel = ~(4'b0001 << dg);
                if (dg == 1) segSel = (((sc / 8) % 2) == 1) ? BLANK : segTab[5];
                else segSel = segTab[dg];
                scan(anSel, segSel, 1'b1, 10);
            end
        end
        check("blink_value", 32'(blink), 32'h2);
        check("blink_frames", 32'(frameCnt), 32'd60);

        // Random scanning against the model
        doReset();
        for (int n = 0; n < 250; n++) begin
            int         r;
            int         dw;
            logic [3:0] anR;
            logic [6:0] segR;
            r = int'($urandom_range(0, 9));
            if (r < 8) anR = ~(4'b0001 << (r % 4));
            else if (r == 8) anR = IDLE_AN;
            else anR = 4'($urandom);
            r = int'($urandom_range(0, 19));
            if (r < 16) segR = segTab[r];
            else if (r < 18) segR = BLANK;
            else segR = 7'($urandom);
            dw = int'($urandom_range(1, 12));
            setBus(anR, segR, 1'($urandom));
            for (int k = 0; k < dw; k++) begin
                errClr = ($urandom_range(0, 7) == 0);
                step();
            end
            errClr = 1'b0;
            if ($urandom_range(0, 39) == 0) doReset();
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
